aes_round_seq: RTL and testbench

AES_ROUND_SEQ -- requirements
Module: aes_round_seq

---
 rtl/aes_seq_pkg.sv | 35 +++
 rtl/aes_round_cnt.sv | 27 ++
 rtl/aes_round_seq.sv | 134 +++++++++++++
 tb/tb_aes_round_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_seq_pkg.sv
// aes_seq_pkg: shared definitions for the AES round sequencer.
//   - state_t       : sequencer FSM encoding
//   - KM_*          : KeyMode codes
//   - NR_*_DEF      : default round counts per key size
//   - nr_of_mode()  : maps a legal KeyMode to its round count
package aes_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] KM_128 = 2'b00;
    localparam logic [1:0] KM_192 = 2'b01;
    localparam logic [1:0] KM_256 = 2'b10;
    localparam logic [1:0] KM_ILL = 2'b11;

    localparam int NR_128_DEF = 10;
    localparam int NR_192_DEF = 12;
    localparam int NR_256_DEF = 14;

    // KM_ILL never reaches here (rejected before acceptance); it falls back to 128.
    function automatic int nr_of_mode(input logic [1:0] km, input int n128,
                                      input int n192, input int n256);
        case (km)
            KM_192:  return n192;
            KM_256:  return n256;
            default: return n128;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_cnt.sv
// aes_round_cnt: W-bit round up-counter.
//   Clk, Rst (async, active-low) : clock / reset
//   Clr    : synchronous clear (wins over En)
//   En     : count enable
//   Limit  : runtime saturation value; Cnt never passes it
//   Cnt    : current count
module aes_round_cnt #(
    parameter int W = 4
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Clr,
    input  logic         En,
    input  logic [W-1:0] Limit,
    output logic [W-1:0] Cnt
);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            Cnt <= '0;
        else if (Clr)
            Cnt <= '0;
        else if (En && (Cnt < Limit))
            Cnt <= Cnt + 1'b1;
    end

endmodule

// File: rtl/aes_round_seq.sv
// aes_round_seq: AES round control sequencer (IDLE -> INIT -> ROUND.. -> FINAL -> DONE).
//   Clk, Rst (async, active-low)
//   Start   : begin one block operation (accepted only in IDLE, legal KeyMode)
//   Stall   : freeze INIT/ROUND/FINAL for this cycle
//   KeyMode : 00=128, 01=192, 10=256, 11=illegal (ModeErr pulse)
//   Dec     : decrypt direction, present only with AES_DECRYPT_EN
//   Round   : current round 0..Nr
//   RkIdx   : round-key index (Round, or Nr-Round when decrypting)
//   SubEn, MixEn           : datapath enables
//   Busy, Done, ModeErr    : status
// Optional feature macro: AES_DECRYPT_EN (adds Dec and reversed key order).
module aes_round_seq
    import aes_seq_pkg::*;
#(
    parameter int CNT_W  = 4,
    parameter int NR_128 = NR_128_DEF,
    parameter int NR_192 = NR_192_DEF,
    parameter int NR_256 = NR_256_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Stall,
    input  logic [1:0]       KeyMode,
`ifdef AES_DECRYPT_EN
    input  logic             Dec,
`endif
    output logic [CNT_W-1:0] Round,
    output logic [CNT_W-1:0] RkIdx,
    output logic             SubEn,
    output logic             MixEn,
    output logic             Busy,
    output logic             Done,
    output logic             ModeErr
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] nr_q;
    logic             accept, mode_err_nxt, cnt_clr, cnt_en;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state   <= S_IDLE;
            nr_q    <= CNT_W'(NR_128);
            ModeErr <= 1'b0;
        end else begin
            state   <= state_nxt;
            ModeErr <= mode_err_nxt;
            if (accept)
                nr_q <= CNT_W'(nr_of_mode(KeyMode, NR_128, NR_192, NR_256));
        end
    end

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        mode_err_nxt = 1'b0;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;
        SubEn        = 1'b0;
        MixEn        = 1'b0;
        Busy         = 1'b0;
        Done         = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_clr = 1'b1;
                if (Start) begin
                    if (KeyMode == KM_ILL) begin
                        mode_err_nxt = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = S_INIT;
                    end
                end
            end
            S_INIT: begin
                Busy = 1'b1;
                if (!Stall) begin
                    cnt_en    = 1'b1;
                    state_nxt = S_ROUND;
                end
            end
            S_ROUND: begin
                Busy  = 1'b1;
                SubEn = 1'b1;
                MixEn = 1'b1;
                if (!Stall) begin
                    cnt_en = 1'b1;
                    // Last full round: the increment lands on Nr as we enter FINAL.
                    if (Round == nr_q - 1'b1)
                        state_nxt = S_FINAL;
                end
            end
            S_FINAL: begin
                Busy  = 1'b1;
                SubEn = 1'b1;
                if (!Stall)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                Done      = 1'b1;
                cnt_clr   = 1'b1;  // Round shows Nr here, 0 back in IDLE
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    aes_round_cnt #(.W(CNT_W)) u_cnt (
        .Clk   (Clk),
        .Rst   (Rst),
        .Clr   (cnt_clr),
        .En    (cnt_en),
        .Limit (nr_q),
        .Cnt   (Round)
    );

`ifdef AES_DECRYPT_EN
    logic dec_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            dec_q <= 1'b0;
        else if (accept)
            dec_q <= Dec;
    end

    // Reverse key order only while an operation is live so IDLE reads 0.
    assign RkIdx = (dec_q && (state != S_IDLE)) ? (nr_q - Round) : Round;
`else
    assign RkIdx = Round;
`endif

endmodule

// File: tb/tb_aes_round_seq.sv
module tb_aes_round_seq;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Start = 1'b0;
    logic       Stall = 1'b0;
    logic [1:0] KeyMode = 2'b00;
`ifdef AES_DECRYPT_EN
    logic       Dec = 1'b0;
`endif
    logic [3:0] Round, RkIdx;
    logic       SubEn, MixEn, Busy, Done, ModeErr;

    int n_cmp = 0;
    int n_bad = 0;

    aes_round_seq dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Start   (Start),
        .Stall   (Stall),
        .KeyMode (KeyMode),
`ifdef AES_DECRYPT_EN
        .Dec     (Dec),
`endif
        .Round   (Round),
        .RkIdx   (RkIdx),
        .SubEn   (SubEn),
        .MixEn   (MixEn),
        .Busy    (Busy),
        .Done    (Done),
        .ModeErr (ModeErr)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // One vector: KeyMode, its Nr, round at which to stall (s) and for how many cycles (l).
    typedef struct {
        logic [1:0] km;
        int         nr;
        int         s;
        int         l;
    } vec_t;

    vec_t vecs[6];

    // Called at a negedge. Cycle k = k-th negedge after Start was driven.
    task automatic run_vec(input vec_t v, input int idx);
        int done_k, stalls, er;
        bit sub_e, mix_e, busy_e;
        string tag;
        done_k = v.nr + 2 + v.l;
        stalls = 0;
        KeyMode = v.km;
        Start = 1'b1;
        for (int k = 1; k <= done_k + 1; k++) begin
            @(negedge Clk);
            if (k == 1) begin
                Start = 1'b0;
                KeyMode = v.km ^ 2'b01;  // must not matter after acceptance
            end
            if (k > done_k) er = 0;
            else begin
                er = k - 1;
                if (k - 1 > v.s) er = (k - 1 - v.l < v.s) ? v.s : k - 1 - v.l;
                if (er > v.nr) er = v.nr;
            end
            busy_e = (k >= 1) && (k < done_k);
            sub_e  = (k >= 2) && (k < done_k);
            mix_e  = sub_e && (er < v.nr);
            tag = $sformatf("vec%0d k%0d", idx, k);
            chk({tag, " Round"}, Round, er);
            chk({tag, " RkIdx"}, RkIdx, er);
            chk({tag, " SubEn"}, SubEn, sub_e);
            chk({tag, " MixEn"}, MixEn, mix_e);
            chk({tag, " Busy"}, Busy, busy_e);
            chk({tag, " Done"}, Done, k == done_k);
            if (er == v.s && stalls < v.l) begin
                Stall = 1'b1;
                stalls++;
            end else Stall = 1'b0;
        end
        Stall = 1'b0;
    endtask

    initial begin
        int dones, done_at, maxr;

        vecs[0] = '{2'b00, 10, 99, 0};
        vecs[1] = '{2'b01, 12, 99, 0};
        vecs[2] = '{2'b10, 14, 99, 0};
        vecs[3] = '{2'b10, 14, 5, 3};   // Done at t+19
        vecs[4] = '{2'b00, 10, 9, 2};   // stall on the last full round
        vecs[5] = '{2'b01, 12, 1, 1};

        // Reset state
        repeat (3) @(negedge Clk);
        chk("rst Round", Round, 0);
        chk("rst RkIdx", RkIdx, 0);
        chk("rst SubEn", SubEn, 0);
        chk("rst MixEn", MixEn, 0);
        chk("rst Busy", Busy, 0);
        chk("rst Done", Done, 0);
        chk("rst ModeErr", ModeErr, 0);
        Rst = 1'b1;
        @(negedge Clk);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
            @(negedge Clk);
        end

        // Illegal KeyMode
        KeyMode = 2'b11;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        chk("moderr pulse", ModeErr, 1);
        chk("moderr Busy", Busy, 0);
        chk("moderr Round", Round, 0);
        @(negedge Clk);
        chk("moderr end", ModeErr, 0);
        chk("moderr Busy2", Busy, 0);

        // Stall during DONE is ignored
        KeyMode = 2'b00;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (11) @(negedge Clk);
        chk("dstall Done", Done, 1);
        Stall = 1'b1;
        @(negedge Clk);
        chk("dstall idle Done", Done, 0);
        chk("dstall idle Busy", Busy, 0);
        chk("dstall idle Round", Round, 0);
        Stall = 1'b0;
        @(negedge Clk);

        // Start repeated while busy and in DONE
        dones = 0;
        done_at = 0;
        KeyMode = 2'b00;
        Start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge Clk);
            if (Done) begin
                dones++;
                done_at = k;
            end
            Start = (k >= 2 && k <= 12);
        end
        Start = 1'b0;
        chk("restart dones", dones, 1);
        chk("restart done cycle", done_at, 12);
        chk("restart idle Busy", Busy, 0);

        // Reset mid-operation at Round 7, KeyMode 01
        KeyMode = 2'b01;
        Start = 1'b1;
        repeat (8) begin
            @(negedge Clk);
            Start = 1'b0;
        end
        chk("abort pre Round", Round, 7);
        #2 Rst = 1'b0;
        #1;
        chk("abort Round", Round, 0);
        chk("abort RkIdx", RkIdx, 0);
        chk("abort Busy", Busy, 0);
        chk("abort SubEn", SubEn, 0);
        chk("abort MixEn", MixEn, 0);
        chk("abort Done", Done, 0);
        @(negedge Clk);
        Rst = 1'b1;
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            if (Done) dones++;
        end
        chk("abort no Done", dones, 0);
        chk("abort idle Busy", Busy, 0);
        KeyMode = 2'b01;
        Start = 1'b1;
        done_at = 0;
        maxr = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clk);
            Start = 1'b0;
            if (int'(Round) > maxr) maxr = int'(Round);
            if (Done && done_at == 0) done_at = k;
        end
        chk("fresh done cycle", done_at, 14);
        chk("fresh max Round", maxr, 12);

`ifdef AES_DECRYPT_EN
        // Decrypt: RkIdx runs 12..0 while Round runs 0..12
        KeyMode = 2'b01;
        Dec = 1'b1;
        Start = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            int er;
            @(negedge Clk);
            Start = 1'b0;
            Dec = 1'b0;  // latched at acceptance
            er = (k - 1 > 12) ? 12 : k - 1;
            chk($sformatf("dec k%0d Round", k), Round, er);
            chk($sformatf("dec k%0d RkIdx", k), RkIdx, 12 - er);
        end
        @(negedge Clk);
        chk("dec idle RkIdx", RkIdx, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
